kanagawa_sim_mailbox_arbiter: RTL and testbench

// - Shares one valid-only mailbox sink (no backpressure) between NUM_REQ valid/ready producers.
// - Round-robin arbitration with bounded burst ownership; one beat per cycle max; registered output.
// - Output tags each beat with its source index so the sink/testbench can demux per producer.
// - Sits between DUT-side producer models and the simulation mailbox sink in Kanagawa benches.

---
 rtl/kanagawa_sim_arb_pkg.sv | 33 +++
 rtl/kanagawa_rr_picker.sv | 22 ++
 rtl/kanagawa_sim_mailbox_arbiter.sv | 116 +++++++++++
 tb/tb_kanagawa_sim_mailbox_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/kanagawa_sim_arb_pkg.sv
// Shared state type and round-robin pick helper for the Kanagawa sim mailbox schedulers.
package kanagawa_sim_arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;

  localparam int ARB_MAX_REQ = 32;
  localparam int ARB_IDX_W   = 5;
  localparam int ARB_NUM_W   = ARB_IDX_W + 1;

  typedef logic [ARB_NUM_W-1:0] arb_num_t;
  typedef struct packed {
    logic                 found;
    logic [ARB_IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of valid & ~exclude scanning ptr, ptr+1, ... modulo n (n <= ARB_MAX_REQ).
  function automatic rr_pick_t rr_pick(input logic [ARB_MAX_REQ-1:0] valid,
                                       input logic [ARB_MAX_REQ-1:0] exclude,
                                       input arb_num_t ptr, input arb_num_t n);
    rr_pick_t r;
    arb_num_t j;
    r = '0;
    // Walk from the far end so the candidate nearest the pointer is written last.
    for (int k = ARB_MAX_REQ - 1; k >= 0; k--) begin
      j = ptr + arb_num_t'(k);
      if (j >= n) j = j - n;
      if (arb_num_t'(k) < n && valid[j[ARB_IDX_W-1:0]] && !exclude[j[ARB_IDX_W-1:0]]) begin
        r.found = 1'b1;
        r.idx   = j[ARB_IDX_W-1:0];
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/kanagawa_rr_picker.sv
// Combinational round-robin scan from a pointer, with a per-requester exclude mask.
module kanagawa_rr_picker
  import kanagawa_sim_arb_pkg::*;
#(
  parameter int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_valid,
  input  logic [N-1:0]  i_exclude,
  input  logic [IW-1:0] i_ptr,
  output logic          o_found,
  output logic [IW-1:0] o_idx
);
  rr_pick_t w_pick;
  logic     w_unused_idx;

  assign w_pick       = rr_pick(ARB_MAX_REQ'(i_valid), ARB_MAX_REQ'(i_exclude),
                                arb_num_t'(i_ptr), arb_num_t'(N));
  assign o_found      = w_pick.found;
  assign o_idx        = w_pick.idx[IW-1:0];
  assign w_unused_idx = ^w_pick.idx;
endmodule

// File: rtl/kanagawa_sim_mailbox_arbiter.sv
// Round-robin, burst-capped arbiter merging NUM_REQ valid/ready producers into one
// registered valid-only mailbox beat stream tagged with the source index.
module kanagawa_sim_mailbox_arbiter
  import kanagawa_sim_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4,
  localparam int SRC_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_enable,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic                          o_valid,
  output logic [DATA_WIDTH-1:0]         o_data,
  output logic [SRC_WIDTH-1:0]          o_src,
  output logic                          o_busy
);
  localparam int                CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0]  CAP   = CNT_W'(MAX_BURST);
  localparam logic [SRC_WIDTH-1:0] LAST = SRC_WIDTH'(NUM_REQ - 1);

  function automatic logic [SRC_WIDTH-1:0] inc_mod(input logic [SRC_WIDTH-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  arb_state_t             r_state, w_state_nxt;
  logic [SRC_WIDTH-1:0]   r_owner, w_owner_nxt, r_rr_ptr, w_rr_ptr_nxt;
  logic [SRC_WIDTH-1:0]   w_owner_inc, w_scan_ptr, w_pick_idx, w_fire_idx;
  logic [CNT_W-1:0]       r_burst_cnt, w_burst_cnt_nxt;
  logic [NUM_REQ-1:0]     w_exclude;
  logic                   w_in_burst, w_cap_hit, w_hold, w_pick_found, w_fire;
  logic [DATA_WIDTH-1:0]  w_data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_data
    assign w_data_arr[g] = i_req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign w_in_burst  = (r_state == ARB_BURST);
  assign w_cap_hit   = (r_burst_cnt == CAP);
  assign w_hold      = w_in_burst && i_req_valid[r_owner] && !w_cap_hit;
  assign w_owner_inc = inc_mod(r_owner);
  // A finishing burst rescans from owner+1 in the same cycle; a capped owner sits out one cycle.
  assign w_scan_ptr  = w_in_burst ? w_owner_inc : r_rr_ptr;
  assign w_exclude   = (w_in_burst && w_cap_hit) ? (NUM_REQ'(1) << r_owner) : '0;

  kanagawa_rr_picker #(.N(NUM_REQ)) u_picker (
    .i_valid   (i_req_valid),
    .i_exclude (w_exclude),
    .i_ptr     (w_scan_ptr),
    .o_found   (w_pick_found),
    .o_idx     (w_pick_idx)
  );

  assign w_fire     = i_rst_n && i_enable && (w_hold || w_pick_found);
  assign w_fire_idx = w_hold ? r_owner : w_pick_idx;
  assign o_busy     = w_in_burst;

  always_comb begin
    o_req_ready = '0;
    if (w_fire) o_req_ready[w_fire_idx] = 1'b1;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_owner_nxt     = r_owner;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_burst_cnt_nxt = r_burst_cnt;
    if (i_enable) begin
      if (w_hold) begin
        w_burst_cnt_nxt = r_burst_cnt + 1'b1;
      end else begin
        if (w_in_burst) begin
          w_state_nxt  = ARB_IDLE;
          w_rr_ptr_nxt = w_owner_inc;
        end
        if (w_pick_found) begin
          w_owner_nxt     = w_pick_idx;
          w_burst_cnt_nxt = CNT_W'(1);
          if (MAX_BURST == 1) w_rr_ptr_nxt = inc_mod(w_pick_idx);
          else                w_state_nxt  = ARB_BURST;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ARB_IDLE;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
      o_valid     <= 1'b0;
      o_data      <= '0;
      o_src       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
      o_valid     <= w_fire;
      if (w_fire) begin
        o_data <= w_data_arr[w_fire_idx];
        o_src  <= w_fire_idx;
      end
    end
  end

  a_ready_onehot: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    $onehot0(o_req_ready));
  a_ready_valid: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    ((o_req_ready & ~i_req_valid) == '0));
endmodule

// File: tb/tb_kanagawa_sim_mailbox_arbiter.sv
// Directed bench with an expected-beat queue checked by an independent output monitor.
module tb_kanagawa_sim_mailbox_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;

  typedef struct {
    logic [1:0]    src;
    logic [DW-1:0] data;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            enable = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            valid_out;
  logic [DW-1:0]   data_out;
  logic [1:0]      src_out;
  logic            busy_out;

  logic [DW-1:0]   base [N] = '{32'h0A00, 32'h0B00, 32'h0100, 32'h0D00};
  logic [DW-1:0]   cnt  [N] = '{default: '0};
  logic            tb_clr = 1'b0;
  exp_t            exp_q [$];
  int              n_checks = 0;
  int              n_pass = 0;

  kanagawa_sim_mailbox_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(4)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_enable    (enable),
    .i_req_valid (req_valid),
    .i_req_data  (req_data),
    .o_req_ready (req_ready),
    .o_valid     (valid_out),
    .o_data      (data_out),
    .o_src       (src_out),
    .o_busy      (busy_out)
  );

  always #5 clk = ~clk;

  // Producer models: each presents base+beat_index and advances on a transfer.
  always_comb for (int i = 0; i < N; i++) req_data[i*DW +: DW] = base[i] + cnt[i];
  always @(posedge clk)
    for (int i = 0; i < N; i++)
      if (tb_clr) cnt[i] <= '0;
      else if (req_valid[i] && req_ready[i]) cnt[i] <= cnt[i] + 1;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && valid_out) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL beat_unexpected: got src=%0d data=%h, no beat expected", src_out, data_out);
      end else begin
        e = exp_q.pop_front();
        if (src_out == e.src && data_out == e.data) n_pass++;
        else $display("FAIL beat: got src=%0d data=%h, expected src=%0d data=%h",
                      src_out, data_out, e.src, e.data);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int src, input logic [DW-1:0] data);
    exp_t e;
    e.src  = 2'(src);
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic drain_clr();
    req_valid = '0;
    repeat (3) tick();
    tb_clr = 1'b1;
    tick();
    tb_clr = 1'b0;
  endtask

  initial begin
    int src;
    int nth [N];

    // Reset values, then idle with no requests.
    #3;
    chk("rst_valid", 32'(valid_out), 0);
    chk("rst_data", data_out, 0);
    chk("rst_src", 32'(src_out), 0);
    chk("rst_busy", 32'(busy_out), 0);
    chk("rst_ready", 32'(req_ready), 0);
    tick(); tick();
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("idle_ready", 32'(req_ready), 0);
      chk("idle_valid", 32'(valid_out), 0);
      chk("idle_busy", 32'(busy_out), 0);
      tick();
    end
    drain_clr();

    // Single requester 2: capped at 4 beats, one-cycle yield, then 4 more.
    for (int k = 0; k < 8; k++) push(2, 32'h100 + 32'(k));
    req_valid = 4'b0100;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c == 0) chk("t2_first_ready", 32'(req_ready), 32'h4);
      if (c == 4) chk("t2_cap_ready", 32'(req_ready), 0);
      if (c == 5) begin
        chk("t2_bubble_valid", 32'(valid_out), 0);
        chk("t2_regrant_ready", 32'(req_ready), 32'h4);
      end
      tick();
    end
    drain_clr();

    // All valid, pointer starts at 3: 3x4,0x4,1x4,2x4,3x4 with no bubbles.
    nth = '{default: 0};
    for (int c = 0; c < 20; c++) begin
      src = (3 + c / 4) % 4;
      push(src, base[src] + 32'(nth[src]));
      nth[src]++;
    end
    req_valid = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      src = (3 + c / 4) % 4;
      chk("t3_ready", 32'(req_ready), 32'(1) << src);
      if (c > 0) chk("t3_no_bubble", 32'(valid_out), 1);
      tick();
    end
    drain_clr();

    // Req 1 drops after 2 beats; req 3 takes over in the same cycle.
    push(1, 32'h0B00); push(1, 32'h0B01); push(3, 32'h0D00); push(3, 32'h0D01);
    req_valid = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t4_ready", 32'(req_ready), (c < 2) ? 32'h2 : 32'h8);
      if (c == 2) chk("t4_busy", 32'(busy_out), 1);
      tick();
      if (c == 1) req_valid = 4'b1000;
    end
    drain_clr();

    // Stall mid-burst at burst_cnt=2; owner gets exactly 2 more beats after resume.
    for (int k = 0; k < 4; k++) push(0, 32'h0A00 + 32'(k));
    req_valid = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c >= 2 && c <= 6) begin
        chk("t5_stall_ready", 32'(req_ready), 0);
        chk("t5_stall_busy", 32'(busy_out), 1);
        if (c >= 3) chk("t5_stall_valid", 32'(valid_out), 0);
      end
      if (c == 7) chk("t5_resume_ready", 32'(req_ready), 32'h1);
      if (c == 9) chk("t5_cap_ready", 32'(req_ready), 0);
      tick();
      if (c == 1) enable = 1'b0;
      if (c == 6) enable = 1'b1;
    end
    drain_clr();

    // Reset pulse while a beat is on the output; afterwards req 0 wins over req 3.
    push(3, 32'h0D00);
    req_valid = 4'b1001;
    @(negedge clk);
    chk("t6_first_ready", 32'(req_ready), 32'h8);
    tick(); tick();
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(valid_out), 0);
    chk("t6_rst_busy", 32'(busy_out), 0);
    chk("t6_rst_ready", 32'(req_ready), 0);
    tb_clr = 1'b1;
    tick();
    tb_clr = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) push(0, 32'h0A00 + 32'(k));
    push(3, 32'h0D00);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t6_ready", 32'(req_ready), (c < 4) ? 32'h1 : 32'h8);
      tick();
    end
    req_valid = '0;
    repeat (4) tick();

    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
